seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
Shares the 4-digit 7-segment display between NUM_REQ requesters, e.g. the note readout, octave/volume overlays and the tuner. Uses fixed priority arbitration with a minimum hold time per grant. Re-arbitrates and snapshots patterns only at frame boundaries, so a frame never mixes two sources. Drives the multiplexed an/seg scan itself; an and seg are registered together so they never glitch.

Parameters:
NUM_REQ, 2, number of requesters; index 0 has highest priority.
SCAN_DIV, 200000, clk cycles per digit tick (about 250 Hz at 50 MHz); must be at least 2.
HOLD_FRAMES, 50, minimum full frames a grant is kept; must be at least 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  NUM_REQ  level request per requester
req_pattern  in  NUM_REQ*28  per requester: 4 digits x 7 segments, active-low; bits [6:0] = digit0 (an[0], rightmost), [27:21] = digit3
idle_pattern  in  28  shown when no grant
gnt  out  NUM_REQ  one-hot current owner; all zero when idle
an  out  4  active-low digit enable, one-hot-low
seg  out  7  active-low segments for the enabled digit

Behaviour:
- Reset (async, while rst=1): an=4'b1111, seg=7'b1111111, gnt=0.
- Reset also clears internal state: prescaler=0, digit=3, hold_cnt=0, snapshot=all ones, state IDLE.
- Prescaler counts 0..SCAN_DIV-1. tick=1 in the cycle where count==SCAN_DIV-1, then count wraps to 0.
- First tick occurs SCAN_DIV cycles after rst deasserts.
- On tick: digit <= digit+1 (wraps 3->0). In the same edge, an <= ~(1<<new digit) and seg <= snapshot[new digit].
- Between ticks, an and seg are held constant.
- Frame boundary = a tick where digit goes 3->0. Arbitration, gnt update and snapshot load all happen on that edge.
- The digit-0 seg value loaded on a frame boundary comes from the newly selected source (combinational next-snapshot).
- States: IDLE, OWNED(k).
- Boundary with hold_cnt != 0:
  - Keep the owner and decrement hold_cnt.
  - Re-snapshot the owner's req_pattern even if its req has dropped, so live updates (note changes) still appear.
- Boundary with hold_cnt == 0 (free boundary):
  - Winner = lowest index with req=1.
  - If the winner equals the current owner: keep it and re-snapshot; hold_cnt stays 0, so every later boundary stays free.
  - If the winner is new: gnt <= onehot(winner), snapshot its pattern, hold_cnt <= HOLD_FRAMES-1.
  - If no req: go to IDLE, gnt=0, snapshot idle_pattern. IDLE has no hold.
- Requests, request drops and pattern changes between boundaries are ignored. The displayed frame is always one consistent snapshot.
- A higher-priority req arriving during a hold waits for the first free boundary. There is no preemption inside the hold.
- If req and its drop both happen within one frame and req=0 at the boundary, no grant is issued.
- Reset mid-frame: blanks immediately (async). Scanning restarts from the post-reset state; the first tick is a free boundary.
- Width rules:
  - Prescaler width = clog2(SCAN_DIV).
  - hold_cnt width = clog2(HOLD_FRAMES+1).
  - Digit index is 2 bits with natural wrap.

Decomposition:
- Shared package display_pkg: NUM_DIGITS=4, SEG_BLANK=7'b1111111, AN_OFF=4'b1111, PATTERN_W=28.
- display_pkg also holds the note-letter segment constants C, D, E, F, G, A, B and dash, which requesters use to build patterns.
- One sub-module: display_scan_tick (parameter SCAN_DIV; ports clk, rst, tick). It is the async-reset prescaler.
- Arbitration, hold counter and scan registers stay in the top module.

Test Plan:
(All tests use SCAN_DIV=4 and HOLD_FRAMES=2, giving a tick every 4 cycles and a frame every 16 cycles.)
- Reset/idle: rst high -> an=1111, seg=1111111, gnt=00. Release, req=00, idle_pattern=28'h0ABCDEF.
  -> at cycle 4: an=1110, seg=idle[6:0]. Then an=1101/1011/0111 every 4 cycles with matching slices.
- Single grant: req=10 before the first boundary, pattern1 digit0=7'b1000110 (C) -> gnt=10 on the boundary edge, seg=1000110 with an=1110.
- Hold blocks preemption: requester 1 owns, req0 rises 2 cycles after the grant boundary.
  -> gnt stays 10 at the next boundary (+16 cycles).
  -> gnt=01 at the second boundary (+32), with digit0 from pattern0.
- Release to idle: owner drops req at +3 cycles. Owner's pattern still shows for 2 frames; at +32 gnt=00 and the idle pattern shows.
- Mid-frame change: pattern0 digit2 changes while an=1101 -> no change at the digit-2 tick in that frame; the new value appears in the next frame.
- Async reset mid-scan: assert rst between clock edges during an=1011 -> an=1111 and seg=1111111 with no clock edge. After release, the first tick again drives an=1110.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants, segment glyphs and the pattern helper used by
// the display arbiter and by requesters that build 4-digit patterns.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PATTERN_W  = NUM_DIGITS * SEG_W;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_C    = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D    = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E    = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F    = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_G    = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_A    = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B    = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

  typedef logic [PATTERN_W-1:0] pattern_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  function automatic logic [SEG_W-1:0] pat_digit(input pattern_t p, input logic [1:0] d);
    return p[int'(d) * SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Digit-scan prescaler: one-cycle tick every SCAN_DIV clocks.
module display_scan_tick #(
  parameter int unsigned SCAN_DIV = 200000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the 4-digit 7-segment display with per-grant hold;
// arbitration and pattern snapshot happen only at frame boundaries.
module seg_display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned SCAN_DIV    = 200000,
  parameter int unsigned HOLD_FRAMES = 50
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PATTERN_W-1:0]   req_pattern,
  input  logic [PATTERN_W-1:0]           idle_pattern,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_DIGITS-1:0]          an,
  output logic [SEG_W-1:0]               seg
);

  localparam int unsigned OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic                  w_tick;
  logic                  w_boundary;
  logic [1:0]            w_digit_nxt;
  logic                  w_win_valid;
  logic [OWN_W-1:0]      w_win;
  pattern_t              w_own_pat;
  pattern_t              w_win_pat;
  arb_state_t            w_state_nxt;
  logic [OWN_W-1:0]      w_owner_nxt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  pattern_t              w_snap_nxt;
  logic [NUM_REQ-1:0]    w_gnt_nxt;

  arb_state_t            r_state;
  logic [OWN_W-1:0]      r_owner;
  logic [HOLD_W-1:0]     r_hold;
  pattern_t              r_snap;
  logic [1:0]            r_digit;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]      r_seg;

  display_scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_digit_nxt = r_digit + 2'd1;
  assign w_boundary  = w_tick && (r_digit == 2'd3);

  // Lowest-index requester wins; also pick out owner and winner patterns
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = '0;
    w_own_pat   = '1;
    w_win_pat   = '1;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_win_valid = 1'b1;
        w_win       = OWN_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (OWN_W'(k) == r_owner) w_own_pat = req_pattern[k * PATTERN_W +: PATTERN_W];
      if (OWN_W'(k) == w_win)   w_win_pat = req_pattern[k * PATTERN_W +: PATTERN_W];
    end
  end

  // Next arbitration state; only takes effect on a frame boundary
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_snap_nxt  = r_snap;
    if (w_boundary) begin
      if ((r_state == ST_OWNED) && (r_hold != '0)) begin
        w_hold_nxt = r_hold - HOLD_W'(1);
        w_snap_nxt = w_own_pat;
      end else if (w_win_valid) begin
        w_snap_nxt = w_win_pat;
        if (!((r_state == ST_OWNED) && (w_win == r_owner))) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_win;
          w_hold_nxt  = HOLD_W'(HOLD_FRAMES - 1);
        end
      end else begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        w_snap_nxt  = idle_pattern;
      end
    end
    w_gnt_nxt = (w_state_nxt == ST_OWNED) ? (NUM_REQ'(1) << w_owner_nxt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_hold  <= '0;
      r_snap  <= '1;
      r_digit <= 2'd3;
      r_gnt   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
      r_snap  <= w_snap_nxt;
      r_digit <= w_digit_nxt;
      r_gnt   <= w_gnt_nxt;
      r_an    <= ~(4'b0001 << w_digit_nxt);
      r_seg   <= pat_digit(w_snap_nxt, w_digit_nxt);
    end
  end

  assign gnt = r_gnt;
  assign an  = r_an;
  assign seg = r_seg;

endmodule
